// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage after the VGA sync generator: 2x-upscaled frame-buffer read, palette, sync delay
// and front/back buffer swap handshake. Define VGA_PIXEL_FETCH_TEST_PATTERN_EN for a colour-checker pattern.
module vga_pixel_fetch #(
    parameter int FB_W     = 320,
    parameter int FB_H     = 240,
    parameter int ADDR_W   = 17,
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255,
    parameter int RD_LAT   = 1
) (
    input  logic              CLK_100MHz,
    input  logic              reset_n,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic              rd_en,
    output logic [ADDR_W:0]   rd_addr,
    input  logic [ITER_W-1:0] rd_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              back_sel,
    output logic [11:0]       rgb,
    output logic              hsync_out,
    output logic              vsync_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [8:0]        x_half_s;
    logic [8:0]        y_half_s;
    logic [ADDR_W-1:0] row_base_s;
    logic [ADDR_W-1:0] cell_s;
    logic              von_r;
    logic              hs_r;
    logic              vs_r;
    logic              vs_prev_r;
    logic              boundary_s;
    logic [RD_LAT-1:0] von_dly_r;
    logic [RD_LAT-1:0] hs_dly_r;
    logic [RD_LAT-1:0] vs_dly_r;
    logic              front_sel_r;
    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              swap_s;
    logic [ITER_W-1:0] cnt_s;
    logic [11:0]       rgb_nxt_s;
    logic              unused_s;

    assign x_half_s   = pixel_x[9:1];
    assign y_half_s   = pixel_y[9:1];
    assign boundary_s = vs_r & ~vs_prev_r;
    assign back_sel   = ~front_sel_r;

    // Row base = y_half * FB_W as a sum of constant shifts (one term per set bit of FB_W)
    always_comb begin
        row_base_s = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (FB_W[i]) begin
                row_base_s = row_base_s + (ADDR_W'(y_half_s) << i);
            end else begin
                row_base_s = row_base_s;
            end
        end
        cell_s = row_base_s + ADDR_W'(x_half_s);
    end

    // Stage 0 capture, BRAM request and sync/active delay line matching the BRAM latency
    always_ff @(posedge CLK_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            von_r     <= 1'b0;
            hs_r      <= 1'b0;
            vs_r      <= 1'b0;
            vs_prev_r <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            von_dly_r <= '0;
            hs_dly_r  <= '0;
            vs_dly_r  <= '0;
        end else begin
            von_r     <= video_on;
            hs_r      <= hsync_in;
            vs_r      <= vsync_in;
            vs_prev_r <= vs_r;
            rd_en     <= video_on;
            if (video_on) begin
                rd_addr <= {front_sel_r, cell_s};
            end
            von_dly_r[0] <= von_r;
            hs_dly_r[0]  <= hs_r;
            vs_dly_r[0]  <= vs_r;
            for (int i = 1; i < RD_LAT; i++) begin
                von_dly_r[i] <= von_dly_r[i-1];
                hs_dly_r[i]  <= hs_dly_r[i-1];
                vs_dly_r[i]  <= vs_dly_r[i-1];
            end
        end
    end

`ifdef VGA_PIXEL_FETCH_TEST_PATTERN_EN
    logic [ITER_W-1:0] tp_r;
    logic [ITER_W-1:0] tp_dly_r [RD_LAT];

    // Checker count rides the same delay line as video_on so latency is unchanged
    always_ff @(posedge CLK_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            tp_r <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tp_dly_r[i] <= '0;
            end
        end else begin
            tp_r        <= ITER_W'({pixel_x[7:4], pixel_y[7:4]});
            tp_dly_r[0] <= tp_r;
            for (int i = 1; i < RD_LAT; i++) begin
                tp_dly_r[i] <= tp_dly_r[i-1];
            end
        end
    end

    assign cnt_s    = tp_dly_r[RD_LAT-1];
    assign unused_s = ^{pixel_x[0], pixel_y[0], rd_data, (FB_H != 0)};
`else
    assign cnt_s    = rd_data;
    assign unused_s = ^{pixel_x[0], pixel_y[0], (FB_H != 0)};
`endif

    // Palette: blank outside the active area, black for points inside the set
    always_comb begin
        rgb_nxt_s = 12'h000;
        if (!von_dly_r[RD_LAT-1]) begin
            rgb_nxt_s = 12'h000;
        end else if (cnt_s == ITER_W'(MAX_ITER)) begin
            rgb_nxt_s = 12'h000;
        end else begin
            rgb_nxt_s = {cnt_s[3:0], cnt_s[5:2], cnt_s[7:4]};
        end
    end

    // Output register stage
    always_ff @(posedge CLK_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            rgb       <= 12'h000;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            rgb       <= rgb_nxt_s;
            hsync_out <= hs_dly_r[RD_LAT-1];
            vsync_out <= vs_dly_r[RD_LAT-1];
        end
    end

    // Swap FSM next state: a request armed before a frame boundary swaps once at that boundary
    always_comb begin
        state_nxt_s = state_r;
        swap_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (swap_req) state_nxt_s = ST_ARMED;
                else          state_nxt_s = ST_IDLE;
            end
            ST_ARMED: begin
                if (boundary_s) begin
                    state_nxt_s = ST_DONE;
                    swap_s      = 1'b1;
                end else if (!swap_req) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_DONE: begin
                if (!swap_req) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Swap FSM state, front buffer select and acknowledge pulse
    always_ff @(posedge CLK_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            front_sel_r <= 1'b0;
            swap_ack    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            swap_ack <= swap_s;
            if (swap_s) begin
                front_sel_r <= ~front_sel_r;
            end
        end
    end

endmodule
